prim_subreg_shadow_nwr: RTL
===========================

// Module: prim_subreg_shadow_nwr
// PURPOSE
// - Shadowed SW-RW register slice requiring NumWrites identical consecutive SW writes before commit.
// - Adds partial-sequence timeout, sticky storage error and a HW-update path that bypasses phasing.
// - Sits in generated register files (reg_top) for security-critical config fields.
// - Drop-in superset of the 2-write shadow slice for RW fields.
// PARAMETERS
// - DW            32   data width
// - NumWrites     2    consecutive matching writes needed to commit, range 2..8
// - TimeoutCycles 0    idle cycles before abandoning a partial sequence; 0 = timeout disabled
// - RESVAL        '0   reset value of committed register [DW-1:0]
// PORTS
// - clk_i            in   1    clock
// - rst_ni           in   1    async active-low reset (staged, committed, phase, timer, errors)
// - rst_shadowed_ni  in   1    async active-low reset of shadow copy only
// - re               in   1    SW read strobe; abandons partial sequence
// - we               in   1    SW write strobe
// - wd               in   DW   SW write data
// - de               in   1    HW write enable
// - d                in   DW   HW write data
// - qe               out  1    one-cycle pulse, registered, coincident with q update
// - q                out  DW   committed value to HW
// - qs               out  DW   committed value for SW readback (== q)
// - phase_o          out  $clog2(NumWrites)  current phase (0 = idle)
// - err_update       out  1    combinational pulse: SW write mismatched staged value
// - err_timeout      out  1    one-cycle registered pulse: partial sequence timed out
// - err_storage      out  1    shadow/committed mismatch, sticky until rst_ni
// BEHAVIOUR
// - Reset: q=qs=RESVAL, staged=shadow=~RESVAL, phase_o=0, timer=0, qe=0, all errors 0.
// - Storage regs: staged (~data), shadow (~data), committed. Only SW writes touch staged first.
// - Arbitration: we wins over de in the same cycle; that de is dropped. we wins over re.
// - SW we, phase 0: staged<=~wd; phase->1.
// - SW we, phase 1..NumWrites-2: if ~staged==wd then phase+1, else err_update=1 and phase->0.
// - SW we, phase NumWrites-1: match -> committed<=wd, shadow<=staged, qe=1 next cycle, phase->0;
//   mismatch -> err_update=1, phase->0, committed/shadow unchanged.
// - Staged is never rewritten in phases >0; mismatch leaves staged as-is (overwritten at next phase 0).
// - HW de (no we): committed<=d, staged<=~d, shadow<=~d, qe=1 next cycle, phase->0, timer cleared.
// - re without we: phase->0, timer cleared, no error.
// - Timeout (TimeoutCycles>0): timer counts cycles with phase!=0 and no we; cleared on any we,
//   de or phase return to 0. When timer reaches TimeoutCycles: phase->0, err_timeout pulse next cycle.
// - err_storage = (~shadow != committed) | err_storage_q; err_storage_q latches on first mismatch.
//   While err_storage=1: all writes (we, de) ignored, phase forced 0, err_update suppressed.
// - rst_shadowed_ni alone reloads shadow with ~RESVAL; if committed!=RESVAL this raises err_storage.
// - Phase counter width $clog2(NumWrites); never exceeds NumWrites-1 (no wrap beyond).
// - Latency: commit visible on q and qe one cycle after final write/de.
// STRUCTURE
// - prim_subreg_pkg: add shadow_phase_e-free helper fn phase width; reuse sw_access_e (RW only here).
// - Sub-module prim_subreg_shadow_phase_ctrl: phase counter + timeout timer, outputs
//   stage_en/commit_en/err_timeout; data path and error compare stay in top.
// - SVA: NumWrites in [2:8]; phase_o < NumWrites; no q change without qe.
// TESTING (DW=8, NumWrites=3, TimeoutCycles=4, RESVAL=0)
// - we 0xA5 x3 back-to-back -> q=0xA5 and qe=1 one cycle after 3rd write; no errors.
// - we 0xA5,0xA5,0x5A -> err_update=1 on 3rd write, q stays 0x00, phase_o=0.
// - we 0xA5, re, we 0xA5 x2 -> no commit (phase_o=2); 3rd 0xA5 then commits.
// - we 0xA5, then 4 idle cycles -> err_timeout pulse, phase_o=0; later single 0xA5 does not commit.
// - commit 0xA5, pulse rst_shadowed_ni -> err_storage=1 sticky; we 0x11 x3 and de ignored; rst_ni clears.
// - phase_o=1, we=1 wd=0x11 with de=1 d=0x3C -> SW wins, de dropped; then de 0x3C alone -> q=0x3C, phase 0.

Source files
------------

// File: rtl/prim_subreg_shadow_nwr_pkg.sv
// rtl/prim_subreg_shadow_nwr_pkg.sv - shared types and width helpers for the N-write shadow slice
package prim_subreg_shadow_nwr_pkg;

   typedef enum logic [2:0] {
      SwAccessRW,
      SwAccessRO,
      SwAccessWO,
      SwAccessW1C,
      SwAccessW1S,
      SwAccessW0C,
      SwAccessRC
   } sw_access_e;

   // Phase counter never needs fewer than one bit, even for the 2-write case.
   function automatic int phase_width(int num_writes);
      return (num_writes <= 2) ? 1 : $clog2(num_writes);
   endfunction

   function automatic int timer_width(int timeout_cycles);
      return (timeout_cycles <= 1) ? 1 : $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/prim_subreg_shadow_nwr_if.sv
// rtl/prim_subreg_shadow_nwr_if.sv - SW/HW access and status bundle of the N-write shadow slice
interface prim_subreg_shadow_nwr_if
   import prim_subreg_shadow_nwr_pkg::*;
#(
   parameter int DW        = 32,
   parameter int NumWrites = 2
);
   localparam int PW = phase_width(NumWrites);

   logic          re;
   logic          we;
   logic [DW-1:0] wd;
   logic          de;
   logic [DW-1:0] d;
   logic          qe;
   logic [DW-1:0] q;
   logic [DW-1:0] qs;
   logic [PW-1:0] phase_o;
   logic          err_update;
   logic          err_timeout;
   logic          err_storage;

   modport master (
      output re, we, wd, de, d,
      input  qe, q, qs, phase_o, err_update, err_timeout, err_storage
   );

   modport slave (
      input  re, we, wd, de, d,
      output qe, q, qs, phase_o, err_update, err_timeout, err_storage
   );

endinterface

// File: rtl/prim_subreg_shadow_phase_ctrl.sv
// rtl/prim_subreg_shadow_phase_ctrl.sv - write-phase counter and partial-sequence timeout timer
module prim_subreg_shadow_phase_ctrl
   import prim_subreg_shadow_nwr_pkg::*;
#(
   parameter int NumWrites     = 2,
   parameter int TimeoutCycles = 0,
   parameter int PW            = phase_width(NumWrites)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic          de_i,
   input  logic          re_i,
   input  logic          match_i,
   input  logic          lock_i,
   output logic [PW-1:0] phase_o,
   output logic          stage_en_o,
   output logic          commit_en_o,
   output logic          err_timeout_o
);
   localparam int            TW        = timer_width(TimeoutCycles);
   localparam logic [PW-1:0] LastPhase = PW'(NumWrites - 1);
   localparam logic [TW-1:0] TimerLast = TW'(TimeoutCycles - 1);

   logic [PW-1:0] phase_q;
   logic [TW-1:0] timer_q;
   logic          err_timeout_q;

   assign stage_en_o    = we_i & ~lock_i & (phase_q == '0);
   assign commit_en_o   = we_i & ~lock_i & (phase_q == LastPhase) & match_i;
   assign phase_o       = phase_q;
   assign err_timeout_o = err_timeout_q;

   // Timer only advances while a partial sequence is idle; every other branch clears it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q       <= '0;
         timer_q       <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         err_timeout_q <= 1'b0;
         timer_q       <= '0;
         if (lock_i) begin
            phase_q <= '0;
         end else if (we_i) begin
            if (phase_q == '0) begin
               phase_q <= PW'(1);
            end else if (!match_i || phase_q == LastPhase) begin
               phase_q <= '0;
            end else begin
               phase_q <= phase_q + PW'(1);
            end
         end else if (de_i || re_i) begin
            phase_q <= '0;
         end else if (TimeoutCycles > 0 && phase_q != '0) begin
            if (timer_q == TimerLast) begin
               phase_q       <= '0;
               err_timeout_q <= 1'b1;
            end else begin
               timer_q <= timer_q + TW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/prim_subreg_shadow_nwr.sv
// rtl/prim_subreg_shadow_nwr.sv - shadowed RW register slice committing after N matching SW writes
module prim_subreg_shadow_nwr
   import prim_subreg_shadow_nwr_pkg::*;
#(
   parameter int            DW            = 32,
   parameter int            NumWrites     = 2,
   parameter int            TimeoutCycles = 0,
   parameter logic [DW-1:0] RESVAL        = '0
) (
   input logic                     clk_i,
   input logic                     rst_ni,
   input logic                     rst_shadowed_ni,
   prim_subreg_shadow_nwr_if.slave bus
);
   localparam int PW = phase_width(NumWrites);

   logic [DW-1:0] staged_d, staged_q;
   logic [DW-1:0] shadow_d, shadow_q;
   logic [DW-1:0] committed_d, committed_q;
   logic          qe_q, err_storage_q, err_storage;
   logic          stage_en, commit_en, hw_en, match;
   logic [PW-1:0] phase;

   assign err_storage = (~shadow_q != committed_q) | err_storage_q;
   assign match       = (~staged_q == bus.wd);
   assign hw_en       = bus.de & ~bus.we & ~err_storage;

   prim_subreg_shadow_phase_ctrl #(
      .NumWrites     (NumWrites),
      .TimeoutCycles (TimeoutCycles),
      .PW            (PW)
   ) u_phase_ctrl (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .we_i          (bus.we),
      .de_i          (bus.de),
      .re_i          (bus.re),
      .match_i       (match),
      .lock_i        (err_storage),
      .phase_o       (phase),
      .stage_en_o    (stage_en),
      .commit_en_o   (commit_en),
      .err_timeout_o (bus.err_timeout)
   );

   // Staged and shadow hold inverted data so a stuck-at fault cannot match both copies.
   always_comb begin
      staged_d    = staged_q;
      shadow_d    = shadow_q;
      committed_d = committed_q;
      if (hw_en) begin
         staged_d    = ~bus.d;
         shadow_d    = ~bus.d;
         committed_d = bus.d;
      end else if (stage_en) begin
         staged_d = ~bus.wd;
      end else if (commit_en) begin
         shadow_d    = staged_q;
         committed_d = bus.wd;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         staged_q      <= ~RESVAL;
         committed_q   <= RESVAL;
         qe_q          <= 1'b0;
         err_storage_q <= 1'b0;
      end else begin
         staged_q      <= staged_d;
         committed_q   <= committed_d;
         qe_q          <= hw_en | commit_en;
         err_storage_q <= err_storage;
      end
   end

   always_ff @(posedge clk_i or negedge rst_shadowed_ni) begin
      if (!rst_shadowed_ni) begin
         shadow_q <= ~RESVAL;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign bus.q           = committed_q;
   assign bus.qs          = committed_q;
   assign bus.qe          = qe_q;
   assign bus.phase_o     = phase;
   assign bus.err_update  = bus.we & ~err_storage & (phase != '0) & ~match;
   assign bus.err_storage = err_storage;

   a_num_writes: assert property (@(posedge clk_i) NumWrites >= 2 && NumWrites <= 8);
   a_phase_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      int'(phase) < NumWrites);
   a_q_needs_qe: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (committed_q != $past(committed_q)) |-> qe_q);

endmodule
